// File: rtl/trace_pkg.sv
// Shared types for the commit trace transmitter: record layout, record
// type codes and the transmitter state encoding.
package trace_pkg;

  localparam logic [1:0] REC_REG   = 2'd0;
  localparam logic [1:0] REC_LOAD  = 2'd1;
  localparam logic [1:0] REC_STORE = 2'd2;
  localparam logic [1:0] REC_HALT  = 2'd3;

  // 34-bit trace record {type, a, b}
  typedef struct packed {
    logic [1:0]  rtype;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: up to four contiguous writes per cycle, one read per cycle.
// The head record is driven straight from registered storage and reads as
// all-zero whenever the FIFO is empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    wr_n,
  input  rec_t [3:0]    wr_rec,
  input  logic          rd_en,
  output logic          rd_valid,
  output rec_t          rd_rec,
  output logic [AW:0]   occ
);

  rec_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;

  assign rd_valid = (occ != '0);
  assign pop      = rd_en & rd_valid;
  assign rd_rec   = rd_valid ? mem[rptr] : '0;

  // Pointer and occupancy bookkeeping; the caller never writes more than free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      wptr <= wptr + AW'(wr_n);
      rptr <= rptr + AW'(pop);
      occ  <= occ + (AW+1)'(wr_n) - (AW+1)'(pop);
    end
  end

  // Record storage: slot i of the write bundle lands at wptr+i, wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < wr_n) begin
        mem[wptr + AW'(i)] <= wr_rec[i];
      end
    end
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: encodes per-cycle commit events into REG/LOAD/
// STORE/HALT records, buffers them and drains them over a valid/ready stream.
// A cycle whose records do not all fit is dropped whole; a dropped HALT is
// retried on its own until space appears.
module commit_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] reg_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        halt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_type,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
  output logic        almost_full,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        done
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] inst_count;
  logic [15:0] cycle_count;
  logic [15:0] inst_nxt;
  logic [15:0] cycle_nxt;
  logic [AW:0] occ;
  logic [AW:0] free;
  rec_t [3:0]  cand;
  logic [2:0]  cand_n;
  rec_t [3:0]  wr_rec;
  logic [2:0]  wr_n;
  logic        drop;
  rec_t        head;

  // Free space comes only from registered occupancy; a same-cycle pop is not credited.
  assign free        = (AW+1)'(DEPTH) - occ;
  assign almost_full = (free < (AW+1)'(4));
  assign done        = (state == ST_DONE);
  assign rec_type    = head.rtype;
  assign rec_a       = head.a;
  assign rec_b       = head.b;

  // Counter look-ahead values; the HALT record carries the halt cycle's counts.
  always_comb begin
    inst_nxt  = inst_count + {15'd0, (halt | reg_wr | mem_wr)};
    cycle_nxt = cycle_count + 16'd1;
  end

  // Pack asserted commit events densely in fixed order REG, LOAD, STORE, HALT.
  always_comb begin
    cand   = '0;
    cand_n = '0;
    if (reg_wr) begin
      cand[cand_n[1:0]] = '{rtype: REC_REG, a: {13'd0, reg_sel}, b: reg_data};
      cand_n = cand_n + 3'd1;
    end
    if (mem_rd) begin
      cand[cand_n[1:0]] = '{rtype: REC_LOAD, a: mem_addr, b: mem_rdata};
      cand_n = cand_n + 3'd1;
    end
    if (mem_wr) begin
      cand[cand_n[1:0]] = '{rtype: REC_STORE, a: mem_addr, b: mem_wdata};
      cand_n = cand_n + 3'd1;
    end
    if (halt) begin
      cand[cand_n[1:0]] = '{rtype: REC_HALT, a: inst_nxt, b: cycle_nxt};
      cand_n = cand_n + 3'd1;
    end
  end

  // Next state and FIFO write control.
  always_comb begin
    state_nxt = state;
    wr_rec    = cand;
    wr_n      = '0;
    drop      = 1'b0;
    unique case (state)
      ST_RUN: begin
        if ((AW+1)'(cand_n) <= free) begin
          wr_n = cand_n;
          if (halt) state_nxt = ST_DRAIN;
        end else begin
          drop = 1'b1;
          if (halt) state_nxt = ST_HALT_PEND;
        end
      end
      ST_HALT_PEND: begin
        // Counters are frozen outside RUN, so they already include the halt cycle.
        wr_rec[0] = '{rtype: REC_HALT, a: inst_count, b: cycle_count};
        if (free != '0) begin
          wr_n      = 3'd1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rec_valid && rec_ready && (rec_type == REC_HALT)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, counters and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      inst_count  <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN) begin
        inst_count  <= inst_nxt;
        cycle_count <= cycle_nxt;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_n     (wr_n),
    .wr_rec   (wr_rec),
    .rd_en    (rec_ready),
    .rd_valid (rec_valid),
    .rd_rec   (head),
    .occ      (occ)
  );

endmodule

// File: doc/commit_trace_tx.md
# commit_trace_tx

Synthesizable transmitter for the processor's architectural commit trace. Each cycle it samples the write-back and memory-stage commit signals, encodes them into typed records (REG, LOAD, STORE, HALT), and buffers them in a small FIFO. Records drain one per cycle over a valid/ready stream, in the same order and with the same content as the simulation trace consumer prints them. It sits beside the pipeline in `proc` and is driven by the same qualified RegWrite/MemRead/MemWrite/Halt terms the trace bench uses.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- reg_wr  in  1  qualified register-file write this cycle.
- reg_sel  in  3  destination register.
- reg_data  in  16  register write data.
- mem_rd  in  1  qualified data-memory read.
- mem_wr  in  1  qualified data-memory write.
- mem_addr  in  16  memory address.
- mem_wdata  in  16  store data.
- mem_rdata  in  16  load data.
- halt  in  1  halt committed.
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts the head record.
- rec_type  out  2  record type: 0 REG, 1 LOAD, 2 STORE, 3 HALT.
- rec_a  out  16  REG: {13'b0, reg_sel}; LOAD/STORE: address; HALT: inst_count.
- rec_b  out  16  REG: data; LOAD: rdata; STORE: wdata; HALT: cycle_count.
- almost_full  out  1  free entries < 4; the pipeline may stall on this.
- overflow  out  1  sticky; at least one cycle's records were dropped.
- drop_count  out  8  number of dropped cycles; saturates at 255.
- done  out  1  the HALT record has been accepted by the consumer.

## Operation
- States: RUN, HALT_PEND, DRAIN, DONE. Reset state is RUN.
- RUN, per cycle:
  - Form the candidate records in fixed order REG, LOAD, STORE, HALT. Include only the asserted ones; n is 0 to 4.
  - Let free = DEPTH minus occupancy at the start of the cycle. A same-cycle pop is not credited.
  - If n ≤ free: write all n records at wptr..wptr+n-1, modulo DEPTH, and advance wptr by n.
  - If n > free and halt=0: write nothing, set overflow, and increment drop_count.
  - If n > free and halt=1: drop the non-HALT records, set overflow, increment drop_count, and go to HALT_PEND.
  - If the HALT record was written: go to DRAIN.
- HALT_PEND: write the HALT record alone on the first cycle with free ≥ 1, then go to DRAIN. All inputs are ignored.
- DRAIN: inputs are ignored. When the HALT record is popped (rec_valid & rec_ready & rec_type==3), go to DONE.
- DONE: done=1. The block stays here until rst.
- Counters, 16-bit, wrapping:
  - cycle_count increments every cycle in RUN, including the halt cycle.
  - inst_count increments in RUN when halt | reg_wr | mem_wr. This matches the bench's instruction count.
  - Both counters count regardless of drops. The HALT record carries their values including the halt cycle.
- Pop: when rec_valid & rec_ready, rptr advances by 1. Push and pop in the same cycle are both allowed.
- mem_rd and mem_wr both high: emit LOAD then STORE. This is legal, not an error.

## Timing
- A record pushed at edge N is visible at the head from cycle N+1, provided the FIFO was empty. Push-to-valid latency is 1 cycle.
- Output fields come from registered FIFO storage. They are stable while rec_valid=1 and rec_ready=0.
- almost_full and free are computed from the registered occupancy. They have no combinational path from the inputs.
- Reset values: rec_valid=0, rec_type=0, rec_a=0, rec_b=0, almost_full=0, overflow=0, drop_count=0, done=0. Also cleared: pointers, occupancy, and both counters.
- Reset mid-operation discards all buffered records immediately. The first post-reset cycle samples inputs in RUN.
- Occupancy is (AW+1) bits, so full (occupancy == DEPTH) is distinguishable from empty.

## Structure
- Shared package `trace_pkg` holds:
  - record-type constants REC_REG, REC_LOAD, REC_STORE, REC_HALT;
  - the 34-bit record struct {type, a, b};
  - the state enum.
- One sub-module, `trace_fifo`: DEPTH×34 storage, multi-write (up to 4 contiguous entries per cycle), single read. It exposes occupancy.
- The encoder, FSM and counters live in `commit_trace_tx`.

## Test plan
- Single REG: reg_wr=1, reg_sel=5, reg_data=0x1234, rec_ready=1.
  - Next cycle: rec_valid=1, type 0, a=0x0005, b=0x1234.
  - The cycle after that: rec_valid=0.
- Load with writeback: reg_wr=1 (r2, 0xBEEF), mem_rd=1 (addr 0x0040, rdata 0xBEEF).
  - Two records: REG r2/0xBEEF, then LOAD 0x0040/0xBEEF.
- Overflow, DEPTH=8, rec_ready=0:
  - Push 8 single REG records; almost_full rises once occupancy reaches 5.
  - 9th push: dropped, overflow=1, drop_count=1, occupancy stays 8.
- Halt into a full FIFO: with the FIFO full, halt=1 and reg_wr=1.
  - FSM goes to HALT_PEND and drop_count increments.
  - Release rec_ready: the HALT record appears after the 8 buffered records, with a = inst_count and b = cycle_count.
  - done rises the cycle after the HALT record is accepted.
- Same-cycle push and pop: occupancy 1, rec_ready=1, one STORE pushed (0x0010/0x00AA).
  - Occupancy stays 1 and the order is preserved.
- Reset mid-drain: assert rst with 3 records queued.
  - Next cycle: rec_valid=0, overflow=0, counters=0, state RUN.
